// File: rtl/fwd_hazard_scoreboard_if.sv
// ID-stage <-> forwarding scoreboard bundle: instruction operands in, stall/issue/forward selects out.
interface fwd_hazard_scoreboard_if #(
    parameter int unsigned REG_ADDR_W = 5,
    parameter int unsigned NUM_SRC    = 2,
    parameter int unsigned PIPE_DEPTH = 3
);
    localparam int unsigned SEL_W = $clog2(PIPE_DEPTH + 1);

    logic                          id_valid;
    logic [NUM_SRC*REG_ADDR_W-1:0] id_rs;
    logic [NUM_SRC-1:0]            id_rs_used;
    logic [REG_ADDR_W-1:0]         id_rd;
    logic                          id_reg_write;
    logic                          id_is_load;
    logic                          flush;
    logic                          stall;
    logic                          issue;
    logic [NUM_SRC*SEL_W-1:0]      fwd_sel;

    modport master (
        output id_valid, id_rs, id_rs_used, id_rd, id_reg_write, id_is_load, flush,
        input  stall, issue, fwd_sel
    );

    modport slave (
        input  id_valid, id_rs, id_rs_used, id_rd, id_reg_write, id_is_load, flush,
        output stall, issue, fwd_sel
    );
endinterface

// File: rtl/fwd_hazard_scoreboard.sv
// Shift-register scoreboard of in-flight writes: youngest-producer forward select and load-use stall.
// Optional perf counters (stall_cycles_o, fwd_count_o) under FWD_HAZARD_SCOREBOARD_PERF_EN.
module fwd_hazard_scoreboard #(
    parameter int unsigned REG_ADDR_W = 5,
    parameter int unsigned NUM_SRC    = 2,
    parameter int unsigned PIPE_DEPTH = 3,
    parameter int unsigned LOAD_LAT   = 1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    fwd_hazard_scoreboard_if.slave        sb_if
`ifdef FWD_HAZARD_SCOREBOARD_PERF_EN
    ,
    output logic [31:0]                   stall_cycles_o,
    output logic [31:0]                   fwd_count_o
`endif
);
    localparam int unsigned SEL_W = $clog2(PIPE_DEPTH + 1);

    typedef struct packed {
        logic                  v;
        logic [REG_ADDR_W-1:0] rd;
        logic                  ld;
    } entry_t;

    // Index k-1 holds the producer k stages ahead of ID.
    entry_t ent_q [PIPE_DEPTH];
    entry_t ent_d [PIPE_DEPTH];

    logic                     hazard_c;
    logic                     stall_c;
    logic                     issue_c;
    logic [NUM_SRC*SEL_W-1:0] fwd_sel_c;

    // Descending scan so the smallest matching stage (youngest producer) wins.
    always_comb begin : match_p
        logic [REG_ADDR_W-1:0] rs;
        logic                  haz_op;
        hazard_c  = 1'b0;
        fwd_sel_c = '0;
        rs        = '0;
        haz_op    = 1'b0;
        for (int i = 0; i < int'(NUM_SRC); i++) begin
            rs     = sb_if.id_rs[i*REG_ADDR_W +: REG_ADDR_W];
            haz_op = 1'b0;
            for (int k = int'(PIPE_DEPTH); k >= 1; k--) begin
                if (sb_if.id_rs_used[i] && ent_q[k-1].v && (ent_q[k-1].rd == rs) &&
                    (rs != '0)) begin
                    fwd_sel_c[i*SEL_W +: SEL_W] = SEL_W'(k);
                    haz_op = ent_q[k-1].ld && (k <= int'(LOAD_LAT));
                end
            end
            hazard_c = hazard_c | haz_op;
        end
    end

    assign stall_c = rst_n && sb_if.id_valid && !sb_if.flush && hazard_c;
    assign issue_c = rst_n && sb_if.id_valid && !sb_if.flush && !hazard_c;

    assign sb_if.stall   = stall_c;
    assign sb_if.issue   = issue_c;
    assign sb_if.fwd_sel = fwd_sel_c;

    // Stall, flush and idle cycles all push a bubble into the youngest slot.
    always_comb begin
        ent_d[0].v  = issue_c && sb_if.id_reg_write && (sb_if.id_rd != '0);
        ent_d[0].rd = sb_if.id_rd;
        ent_d[0].ld = sb_if.id_is_load;
        for (int k = 1; k < int'(PIPE_DEPTH); k++) begin
            ent_d[k] = ent_q[k-1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < int'(PIPE_DEPTH); k++) begin
                ent_q[k] <= '0;
            end
        end else begin
            for (int k = 0; k < int'(PIPE_DEPTH); k++) begin
                ent_q[k] <= ent_d[k];
            end
        end
    end

`ifdef FWD_HAZARD_SCOREBOARD_PERF_EN
    logic [31:0] stall_cycles_q, stall_cycles_d;
    logic [31:0] fwd_count_q,    fwd_count_d;

    // Saturating event counters.
    always_comb begin
        stall_cycles_d = stall_cycles_q;
        fwd_count_d    = fwd_count_q;
        if (stall_c && (stall_cycles_q != 32'hFFFF_FFFF)) begin
            stall_cycles_d = stall_cycles_q + 32'd1;
        end
        if (issue_c && (|fwd_sel_c) && (fwd_count_q != 32'hFFFF_FFFF)) begin
            fwd_count_d = fwd_count_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cycles_q <= '0;
            fwd_count_q    <= '0;
        end else begin
            stall_cycles_q <= stall_cycles_d;
            fwd_count_q    <= fwd_count_d;
        end
    end

    assign stall_cycles_o = stall_cycles_q;
    assign fwd_count_o    = fwd_count_q;
`endif

endmodule

// File: tb/tb_fwd_hazard_scoreboard.sv
// Self-checking bench for fwd_hazard_scoreboard: directed scenarios plus random stimulus vs. a queue model.
module tb_fwd_hazard_scoreboard;
    localparam int unsigned RW = 5;
    localparam int unsigned NS = 2;
    localparam int unsigned D  = 3;
    localparam int unsigned LL = 1;
    localparam int unsigned SW = $clog2(D + 1);

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    fwd_hazard_scoreboard_if #(.REG_ADDR_W(RW), .NUM_SRC(NS), .PIPE_DEPTH(D)) sbif ();

`ifdef FWD_HAZARD_SCOREBOARD_PERF_EN
    logic [31:0] stall_cycles;
    logic [31:0] fwd_count;
`endif

    fwd_hazard_scoreboard #(.REG_ADDR_W(RW), .NUM_SRC(NS), .PIPE_DEPTH(D), .LOAD_LAT(LL)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .sb_if          (sbif)
`ifdef FWD_HAZARD_SCOREBOARD_PERF_EN
        ,
        .stall_cycles_o (stall_cycles),
        .fwd_count_o    (fwd_count)
`endif
    );

    // Model: list of in-flight producers, element 0 is the youngest (one stage ahead of ID).
    typedef struct {
        bit v;
        int rd;
        bit ld;
    } ent_t;
    ent_t mdl[$];
    logic [31:0] exp_stall_cycles;
    logic [31:0] exp_fwd_count;

    int errors = 0;
    int checks = 0;

    task automatic clear_model();
        ent_t e;
        e.v = 1'b0; e.rd = 0; e.ld = 1'b0;
        mdl.delete();
        for (int k = 0; k < int'(D); k++) mdl.push_back(e);
        exp_stall_cycles = '0;
        exp_fwd_count    = '0;
    endtask

    function automatic int exp_sel(int i);
        int rs;
        rs = int'(sbif.id_rs[i*RW +: RW]);
        if (!sbif.id_rs_used[i] || rs == 0) return 0;
        for (int k = 1; k <= int'(D); k++)
            if (mdl[k-1].v && mdl[k-1].rd == rs) return k;
        return 0;
    endfunction

    function automatic bit exp_haz();
        int s;
        for (int i = 0; i < int'(NS); i++) begin
            s = exp_sel(i);
            if (s != 0 && mdl[s-1].ld && s <= int'(LL)) return 1'b1;
        end
        return 1'b0;
    endfunction

    function automatic bit exp_stall();
        return rst_n && sbif.id_valid && !sbif.flush && exp_haz();
    endfunction

    function automatic bit exp_issue();
        return rst_n && sbif.id_valid && !sbif.flush && !exp_haz();
    endfunction

    function automatic bit exp_any_fwd();
        for (int i = 0; i < int'(NS); i++) if (exp_sel(i) != 0) return 1'b1;
        return 1'b0;
    endfunction

    // Advance one clock, updating the model from the inputs present before the edge.
    task automatic tick();
        ent_t e;
        bit iss, st, af;
        iss  = exp_issue();
        st   = exp_stall();
        af   = exp_any_fwd();
        e.v  = iss && sbif.id_reg_write && (sbif.id_rd != '0);
        e.rd = int'(sbif.id_rd);
        e.ld = sbif.id_is_load;
        @(posedge clk);
        if (!rst_n) begin
            clear_model();
        end else begin
            mdl.push_front(e);
            void'(mdl.pop_back());
            if (st && exp_stall_cycles != 32'hFFFF_FFFF) exp_stall_cycles = exp_stall_cycles + 32'd1;
            if (iss && af && exp_fwd_count != 32'hFFFF_FFFF) exp_fwd_count = exp_fwd_count + 32'd1;
        end
        #1;
    endtask

    task automatic set_id(bit v, int rs0, int rs1, bit [1:0] used, int rd, bit wr, bit ld, bit fl);
        logic [RW-1:0] a0, a1;
        a0 = RW'(rs0);
        a1 = RW'(rs1);
        sbif.id_valid     = v;
        sbif.id_rs        = {a1, a0};
        sbif.id_rs_used   = used;
        sbif.id_rd        = RW'(rd);
        sbif.id_reg_write = wr;
        sbif.id_is_load   = ld;
        sbif.flush        = fl;
        #1;
    endtask

    task automatic idle(int n);
        set_id(1'b0, 0, 0, 2'b00, 0, 1'b0, 1'b0, 1'b0);
        for (int c = 0; c < n; c++) tick();
    endtask

    task automatic test_reset();
        logic [SW-1:0] f0;
        checks++;
        if (sbif.stall !== 1'b0 || sbif.issue !== 1'b0 || sbif.fwd_sel !== '0) begin
            errors++;
            $display("FAIL reset_init stall=%b issue=%b fwd_sel=%h want 0/0/0", sbif.stall, sbif.issue, sbif.fwd_sel);
        end
        set_id(1'b1, 0, 0, 2'b00, 5, 1'b1, 1'b0, 1'b0);
        tick();
        set_id(1'b1, 5, 0, 2'b01, 0, 1'b0, 1'b0, 1'b0);
        f0 = sbif.fwd_sel[0 +: SW];
        checks++;
        if (f0 !== SW'(1)) begin
            errors++; $display("FAIL reset_pre fwd_sel0 got %0d want 1", f0);
        end
        rst_n = 1'b0;
        clear_model();
        #1;
        checks++;
        if (sbif.stall !== 1'b0 || sbif.issue !== 1'b0 || sbif.fwd_sel !== '0) begin
            errors++;
            $display("FAIL reset_async stall=%b issue=%b fwd_sel=%h want 0/0/0", sbif.stall, sbif.issue, sbif.fwd_sel);
        end
        tick();
        @(negedge clk);
        rst_n = 1'b1;
        set_id(1'b1, 5, 0, 2'b01, 0, 1'b0, 1'b0, 1'b0);
        f0 = sbif.fwd_sel[0 +: SW];
        checks++;
        if (f0 !== SW'(0) || sbif.issue !== 1'b1) begin
            errors++; $display("FAIL reset_post fwd_sel0 got %0d issue %b want 0/1", f0, sbif.issue);
        end
        tick();
    endtask

    task automatic test_alu_chain();
        logic [SW-1:0] f0;
        idle(D);
        set_id(1'b1, 0, 0, 2'b00, 3, 1'b1, 1'b0, 1'b0);
        tick();
        for (int k = 1; k <= int'(D) + 1; k++) begin
            set_id(1'b1, 3, 0, 2'b01, 0, 1'b0, 1'b0, 1'b0);
            f0 = sbif.fwd_sel[0 +: SW];
            checks++;
            if (f0 !== SW'((k <= int'(D)) ? k : 0) || sbif.stall !== 1'b0) begin
                errors++;
                $display("FAIL alu_chain dist=%0d fwd_sel0 got %0d stall %b want %0d/0", k, f0, sbif.stall,
                         (k <= int'(D)) ? k : 0);
            end
            tick();
        end
    endtask

    task automatic test_youngest();
        logic [SW-1:0] f0, f1;
        idle(D);
        set_id(1'b1, 0, 0, 2'b00, 4, 1'b1, 1'b0, 1'b0);
        tick();
        set_id(1'b1, 0, 0, 2'b00, 4, 1'b1, 1'b0, 1'b0);
        tick();
        set_id(1'b1, 0, 4, 2'b10, 0, 1'b0, 1'b0, 1'b0);
        f0 = sbif.fwd_sel[0 +: SW];
        f1 = sbif.fwd_sel[SW +: SW];
        checks++;
        if (f1 !== SW'(1) || f0 !== SW'(0)) begin
            errors++; $display("FAIL youngest fwd_sel1 got %0d fwd_sel0 %0d want 1/0", f1, f0);
        end
        tick();
        set_id(1'b1, 0, 0, 2'b00, 0, 1'b1, 1'b0, 1'b0);
        tick();
        set_id(1'b1, 0, 0, 2'b11, 0, 1'b0, 1'b0, 1'b0);
        checks++;
        if (sbif.fwd_sel !== '0) begin
            errors++; $display("FAIL r0_write fwd_sel got %h want 0", sbif.fwd_sel);
        end
        tick();
    endtask

    task automatic test_load_use();
        logic [SW-1:0] f0;
        idle(D);
        set_id(1'b1, 0, 0, 2'b00, 7, 1'b1, 1'b1, 1'b0);
        tick();
        set_id(1'b1, 7, 0, 2'b01, 0, 1'b0, 1'b0, 1'b0);
        checks++;
        if (sbif.stall !== 1'b1 || sbif.issue !== 1'b0) begin
            errors++; $display("FAIL load_use_stall stall=%b issue=%b want 1/0", sbif.stall, sbif.issue);
        end
        tick();
        f0 = sbif.fwd_sel[0 +: SW];
        checks++;
        if (sbif.stall !== 1'b0 || sbif.issue !== 1'b1 || f0 !== SW'(2)) begin
            errors++;
            $display("FAIL load_use_release stall=%b issue=%b fwd_sel0=%0d want 0/1/2", sbif.stall, sbif.issue, f0);
        end
        tick();
    endtask

    task automatic test_flush();
        logic [SW-1:0] f0, f1;
        idle(D);
        set_id(1'b1, 0, 0, 2'b00, 8, 1'b1, 1'b1, 1'b0);
        tick();
        set_id(1'b1, 8, 0, 2'b01, 9, 1'b1, 1'b0, 1'b1);
        checks++;
        if (sbif.stall !== 1'b0 || sbif.issue !== 1'b0) begin
            errors++; $display("FAIL flush_prio stall=%b issue=%b want 0/0", sbif.stall, sbif.issue);
        end
        tick();
        set_id(1'b1, 9, 8, 2'b11, 0, 1'b0, 1'b0, 1'b0);
        f0 = sbif.fwd_sel[0 +: SW];
        f1 = sbif.fwd_sel[SW +: SW];
        checks++;
        if (f0 !== SW'(0) || f1 !== SW'(2) || sbif.stall !== 1'b0) begin
            errors++;
            $display("FAIL flush_bubble fwd_sel0=%0d fwd_sel1=%0d stall=%b want 0/2/0", f0, f1, sbif.stall);
        end
        tick();
    endtask

    task automatic test_random();
        int bad;
        for (int c = 0; c < 400; c++) begin
            set_id($urandom_range(9, 0) < 8, int'($urandom_range(7, 0)), int'($urandom_range(7, 0)),
                   2'($urandom_range(3, 0)), int'($urandom_range(7, 0)), $urandom_range(9, 0) < 7,
                   $urandom_range(9, 0) < 4, $urandom_range(9, 0) == 0);
            bad = 0;
            checks++;
            for (int i = 0; i < int'(NS); i++)
                if (sbif.fwd_sel[i*SW +: SW] !== SW'(exp_sel(i))) bad++;
            if (sbif.stall !== exp_stall() || sbif.issue !== exp_issue()) bad++;
            if (bad != 0) begin
                errors++;
                $display("FAIL random cyc=%0d fwd_sel=%h stall=%b issue=%b want sel0=%0d sel1=%0d stall=%b issue=%b",
                         c, sbif.fwd_sel, sbif.stall, sbif.issue, exp_sel(0), exp_sel(1), exp_stall(), exp_issue());
            end
            tick();
        end
    endtask

`ifdef FWD_HAZARD_SCOREBOARD_PERF_EN
    task automatic test_perf();
        @(negedge clk);
        rst_n = 1'b0;
        clear_model();
        #1;
        rst_n = 1'b1;
        for (int n = 0; n < 3; n++) begin
            idle(D);
            set_id(1'b1, 0, 0, 2'b00, 7, 1'b1, 1'b1, 1'b0);
            tick();
            set_id(1'b1, 7, 0, 2'b01, 0, 1'b0, 1'b0, 1'b0);
            tick();
            tick();
        end
        idle(1);
        checks++;
        if (stall_cycles !== 32'd3 || fwd_count !== 32'd3) begin
            errors++; $display("FAIL perf_count stall_cycles=%0d fwd_count=%0d want 3/3", stall_cycles, fwd_count);
        end
        force dut.stall_cycles_q = 32'hFFFF_FFFF;
        #1;
        release dut.stall_cycles_q;
        exp_stall_cycles = 32'hFFFF_FFFF;
        set_id(1'b1, 0, 0, 2'b00, 7, 1'b1, 1'b1, 1'b0);
        tick();
        set_id(1'b1, 7, 0, 2'b01, 0, 1'b0, 1'b0, 1'b0);
        tick();
        checks++;
        if (stall_cycles !== 32'hFFFF_FFFF) begin
            errors++; $display("FAIL perf_saturate stall_cycles=%h want ffffffff", stall_cycles);
        end
        idle(1);
    endtask
`endif

    initial begin
        rst_n = 1'b0;
        clear_model();
        set_id(1'b0, 0, 0, 2'b00, 0, 1'b0, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        test_reset();
        test_alu_chain();
        test_youngest();
        test_load_use();
        test_flush();
        test_random();
`ifdef FWD_HAZARD_SCOREBOARD_PERF_EN
        test_perf();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
